// File: rtl/lfsr_pkg.sv
// Shared constants for the 32-bit LFSR (x^32+x^22+x^2+x+1) generator and checker.
package lfsr_pkg;

    localparam int unsigned LfsrW = 32;

    // Feedback taps as bit indices of the state word
    localparam int unsigned Tap0 = 31;
    localparam int unsigned Tap1 = 21;
    localparam int unsigned Tap2 = 1;
    localparam int unsigned Tap3 = 0;

    typedef logic [1:0] state_t;

    localparam state_t StHunt   = 2'd0;
    localparam state_t StVerify = 2'd1;
    localparam state_t StLocked = 2'd2;

endpackage

// File: rtl/lfsr32_next.sv
// Combinational single Fibonacci step of the 32-bit LFSR; used by generator and checker.
module lfsr32_next
    import lfsr_pkg::*;
(
    input  logic [LfsrW-1:0] cur,
    output logic [LfsrW-1:0] nxt
);

    assign nxt = {cur[LfsrW-2:0], cur[Tap0] ^ cur[Tap1] ^ cur[Tap2] ^ cur[Tap3]};

endmodule

// File: rtl/lfsr32_checker.sv
// Receive-side LFSR lock checker: HUNT/VERIFY/LOCKED with flywheel error counting.
// Define LFSR_CHK_BITERR_EN to add the saturating bit_err_count output.
module lfsr32_checker
    import lfsr_pkg::*;
#(
    parameter int unsigned LOCK_CNT   = 4,
    parameter int unsigned UNLOCK_CNT = 3,
    parameter int unsigned ERR_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [LfsrW-1:0] data_in,
    input  logic             data_valid,
    input  logic             clear,
    output logic             locked,
    output logic             err_flag,
    output logic [ERR_W-1:0] err_count
`ifdef LFSR_CHK_BITERR_EN
    ,
    output logic [ERR_W+4:0] bit_err_count
`endif
);

    localparam int unsigned MatchW = $clog2(LOCK_CNT + 1);
    localparam int unsigned MissW  = $clog2(UNLOCK_CNT + 1);

    state_t             state_q, state_d;
    logic [LfsrW-1:0]   expected_q, expected_d;
    logic [MatchW-1:0]  match_cnt_q, match_cnt_d, match_inc;
    logic [MissW-1:0]   miss_cnt_q, miss_cnt_d, miss_inc;
    logic               locked_q, locked_d;
    logic               err_flag_q, err_flag_d;
    logic [ERR_W-1:0]   err_count_q, err_count_d;
    logic [LfsrW-1:0]   data_nxt, exp_nxt;
    logic               hit;
    logic               err_inc;

    lfsr32_next u_next_data (
        .cur (data_in),
        .nxt (data_nxt)
    );

    lfsr32_next u_next_exp (
        .cur (expected_q),
        .nxt (exp_nxt)
    );

    assign hit       = (data_in == expected_q);
    assign match_inc = match_cnt_q + 1'b1;
    assign miss_inc  = miss_cnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        expected_d  = expected_q;
        match_cnt_d = match_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        err_inc     = 1'b0;
        if (data_valid) begin
            case (state_q)
                StHunt: begin
                    // An all-zero word is the LFSR lockup state and carries no phase
                    if (data_in != '0) begin
                        expected_d  = data_nxt;
                        match_cnt_d = MatchW'(1);
                        miss_cnt_d  = '0;
                        state_d     = (LOCK_CNT <= 1) ? StLocked : StVerify;
                    end
                end
                StVerify: begin
                    if (hit) begin
                        expected_d  = data_nxt;
                        match_cnt_d = match_inc;
                        if (match_inc >= MatchW'(LOCK_CNT)) begin
                            state_d    = StLocked;
                            miss_cnt_d = '0;
                        end
                    end else if (data_in != '0) begin
                        expected_d  = data_nxt;
                        match_cnt_d = MatchW'(1);
                    end else begin
                        state_d     = StHunt;
                        match_cnt_d = '0;
                    end
                end
                StLocked: begin
                    // Flywheel: once locked the reference never follows the data
                    expected_d = exp_nxt;
                    if (hit) begin
                        miss_cnt_d = '0;
                    end else begin
                        err_inc    = 1'b1;
                        miss_cnt_d = miss_inc;
                        if (miss_inc >= MissW'(UNLOCK_CNT)) begin
                            state_d     = StHunt;
                            miss_cnt_d  = '0;
                            match_cnt_d = '0;
                        end
                    end
                end
                default: begin
                    state_d     = StHunt;
                    match_cnt_d = '0;
                    miss_cnt_d  = '0;
                end
            endcase
        end
    end

    always_comb begin
        locked_d    = (state_d == StLocked);
        err_flag_d  = err_inc;
        err_count_d = err_count_q;
        if (clear) begin
            err_count_d = '0;
        end else if (err_inc && (err_count_q != '1)) begin
            err_count_d = err_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StHunt;
            expected_q  <= '0;
            match_cnt_q <= '0;
            miss_cnt_q  <= '0;
            locked_q    <= 1'b0;
            err_flag_q  <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            expected_q  <= expected_d;
            match_cnt_q <= match_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            locked_q    <= locked_d;
            err_flag_q  <= err_flag_d;
            err_count_q <= err_count_d;
        end
    end

    assign locked    = locked_q;
    assign err_flag  = err_flag_q;
    assign err_count = err_count_q;

`ifdef LFSR_CHK_BITERR_EN
    localparam int unsigned BitW = ERR_W + 5;

    logic [BitW-1:0] bit_err_q, bit_err_d;
    logic [5:0]      bit_pop;
    logic [BitW:0]   bit_sum;

    assign bit_pop = 6'($countones(data_in ^ expected_q));
    assign bit_sum = {1'b0, bit_err_q} + (BitW + 1)'(bit_pop);

    always_comb begin
        bit_err_d = bit_err_q;
        if (clear) begin
            bit_err_d = '0;
        end else if (data_valid && (state_q == StLocked)) begin
            bit_err_d = bit_sum[BitW] ? '1 : bit_sum[BitW-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_err_q <= '0;
        end else begin
            bit_err_q <= bit_err_d;
        end
    end

    assign bit_err_count = bit_err_q;
`endif

endmodule

// File: tb/tb_lfsr32_checker.sv
// Directed bench for lfsr32_checker with a spec-level reference model; also builds
// with LFSR_CHK_BITERR_EN to cover bit_err_count. A 4-bit-counter copy covers saturation.
module tb_lfsr32_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data_in;
    logic        data_valid;
    logic        clear;
    logic        locked, err_flag;
    logic [15:0] err_count;
    logic        locked_s, err_flag_s;
    logic [3:0]  err_count_s;
`ifdef LFSR_CHK_BITERR_EN
    logic [20:0] bit_err_count;
    logic [8:0]  bit_err_count_s;
`endif

    always #5 clk = ~clk;

    lfsr32_checker dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .data_valid (data_valid),
        .clear      (clear),
        .locked     (locked),
        .err_flag   (err_flag),
        .err_count  (err_count)
`ifdef LFSR_CHK_BITERR_EN
        ,
        .bit_err_count (bit_err_count)
`endif
    );

    lfsr32_checker #(.ERR_W(4)) dut_sat (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .data_valid (data_valid),
        .clear      (clear),
        .locked     (locked_s),
        .err_flag   (err_flag_s),
        .err_count  (err_count_s)
`ifdef LFSR_CHK_BITERR_EN
        ,
        .bit_err_count (bit_err_count_s)
`endif
    );

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    typedef enum {Hunt, Verify, Lock} mode_e;
    mode_e           m_mode;
    logic [31:0]     m_exp;
    int              m_run, m_miss;
    bit              m_flag;
    longint unsigned m_errs, m_bits;
    logic [31:0]     gen;

    // Generator step written as tap-mask parity
    function automatic logic [31:0] nx(input logic [31:0] s);
        return {s[30:0], ^(s & 32'h8020_0003)};
    endfunction

    function automatic longint unsigned capped(input longint unsigned v, input longint unsigned m);
        return (v > m) ? m : v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = Hunt;
        m_exp  = '0;
        m_run  = 0;
        m_miss = 0;
        m_flag = 1'b0;
        m_errs = 0;
        m_bits = 0;
    endtask

    task automatic model_step(input logic [31:0] w, input logic v, input logic c);
        m_flag = 1'b0;
        if (v) begin
            case (m_mode)
                Hunt: if (w != 0) begin
                    m_exp  = nx(w);
                    m_run  = 1;
                    m_mode = Verify;
                end
                Verify: begin
                    if (w == m_exp) begin
                        m_exp = nx(w);
                        m_run++;
                        if (m_run == 4) begin
                            m_mode = Lock;
                            m_miss = 0;
                        end
                    end else if (w != 0) begin
                        m_exp = nx(w);
                        m_run = 1;
                    end else begin
                        m_mode = Hunt;
                        m_run  = 0;
                    end
                end
                Lock: begin
                    m_bits += $countones(w ^ m_exp);
                    if (w == m_exp) m_miss = 0;
                    else begin
                        m_flag = 1'b1;
                        m_errs++;
                        m_miss++;
                    end
                    m_exp = nx(m_exp);
                    if (m_miss == 3) begin
                        m_mode = Hunt;
                        m_miss = 0;
                        m_run  = 0;
                    end
                end
                default: m_mode = Hunt;
            endcase
        end
        if (c) begin
            m_errs = 0;
            m_bits = 0;
        end
    endtask

    task automatic send(input logic [31:0] w, input logic v, input logic c);
        @(negedge clk);
        data_in    = w;
        data_valid = v;
        clear      = c;
        @(posedge clk);
        model_step(w, v, c);
        #1;
    endtask

    task automatic clean(input int n);
        for (int i = 0; i < n; i++) begin
            send(gen, 1'b1, 1'b0);
            gen = nx(gen);
        end
    endtask

    // Reset between edges: locked must drop without waiting for a clock
    task automatic reset_pulse();
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        chk("async_rst_locked", locked, 0);
        chk("async_rst_err_count", err_count, 0);
        rst = 1'b1;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("locked", locked, m_mode == Lock);
                chk("err_flag", err_flag, m_flag);
                chk("err_count", err_count, capped(m_errs, 64'hFFFF));
                chk("sat_locked", locked_s, m_mode == Lock);
                chk("sat_err_flag", err_flag_s, m_flag);
                chk("sat_err_count", err_count_s, capped(m_errs, 64'hF));
`ifdef LFSR_CHK_BITERR_EN
                chk("bit_err_count", bit_err_count, capped(m_bits, 64'h1F_FFFF));
                chk("sat_bit_err_count", bit_err_count_s, capped(m_bits, 64'h1FF));
`endif
            end
        end
    end

    initial begin
        rst        = 1'b0;
        data_in    = '0;
        data_valid = 1'b0;
        clear      = 1'b0;
        model_reset();
        chk_en     = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_locked", locked, 0);
        chk("reset_err_count", err_count, 0);
        rst = 1'b1;

        // Clean stream from seed 0x3039
        chk("model_next_seed", nx(32'h0000_3039), 32'h0000_6073);
        gen = 32'h0000_3039;
        send(gen, 1'b1, 1'b0);
        gen = nx(gen);
        chk("dut_expected_2nd", dut.expected_q, 32'h0000_6073);
        clean(2);
        chk("no_lock_after_3", locked, 0);
        clean(1);
        chk("lock_after_4", locked, 1);
        clean(196);
        chk("err_after_200", err_count, 0);

        // Single all-ones corruption
        send(32'hFFFF_FFFF, 1'b1, 1'b0);
        gen = nx(gen);
        chk("single_err_flag", err_flag, 1);
        chk("single_err_count", err_count, 1);
        chk("single_locked", locked, 1);
        clean(1);
        chk("single_next_flag", err_flag, 0);
        chk("single_next_locked", locked, 1);

        // Three consecutive corruptions drop lock, four clean words relock
        send(gen, 1'b1, 1'b1);
        gen = nx(gen);
        chk("clear_on_match", err_count, 0);
        for (int i = 0; i < 3; i++) begin
            send(gen ^ 32'h0001_0000, 1'b1, 1'b0);
            gen = nx(gen);
            if (i == 1) chk("locked_after_2_bad", locked, 1);
        end
        chk("unlock_after_3_bad", locked, 0);
        chk("err_after_3_bad", err_count, 3);
        clean(3);
        chk("relock_not_yet", locked, 0);
        clean(1);
        chk("relock_after_4", locked, 1);

        // Async reset while locked, then zeros, then gapped valid
        reset_pulse();
        for (int i = 0; i < 10; i++) send(32'h0, 1'b1, 1'b0);
        chk("zeros_hunt", locked, 0);
        for (int i = 0; i < 4; i++) begin
            send(gen, 1'b1, 1'b0);
            gen = nx(gen);
            if (i == 2) chk("gapped_not_yet", locked, 0);
            if (i == 3) chk("gapped_locked", locked, 1);
            send(32'hDEAD_BEEF, 1'b0, 1'b0);
        end
        chk("gapped_hold_locked", locked, 1);

        // VERIFY resync on a foreign word, then a zero word back to HUNT
        reset_pulse();
        clean(2);
        send(32'hCAFE_F00D, 1'b1, 1'b0);
        gen = nx(32'hCAFE_F00D);
        clean(2);
        send(32'h0, 1'b1, 1'b0);
        clean(3);
        chk("rehunt_not_yet", locked, 0);
        clean(1);
        chk("rehunt_locked", locked, 1);

        // Saturation on the 4-bit copy, then clear colliding with an error
        for (int i = 0; i < 16; i++) begin
            send(gen ^ 32'h0000_0004, 1'b1, 1'b0);
            gen = nx(gen);
            clean(1);
        end
        chk("count_16", err_count, 16);
        chk("sat_count_16", err_count_s, 4'hF);
        send(gen ^ 32'h0000_0100, 1'b1, 1'b0);
        gen = nx(gen);
        chk("count_17", err_count, 17);
        chk("sat_hold", err_count_s, 4'hF);
        clean(1);
        send(gen ^ 32'h0000_0100, 1'b1, 1'b1);
        gen = nx(gen);
        chk("clear_wins_count", err_count, 0);
        chk("clear_wins_sat", err_count_s, 0);
        chk("clear_still_flags", err_flag, 1);
        clean(2);
`ifdef LFSR_CHK_BITERR_EN
        send(gen ^ 32'h0000_0007, 1'b1, 1'b0);
        gen = nx(gen);
        chk("bit_err_3", bit_err_count, 3);
`endif
        clean(5);
        chk("final_locked", locked, 1);

        @(negedge clk);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
